// File: rtl/cnt_pkg.sv
// Shared encodings for the counter family: operating modes and the
// one-shot sequencer states.
package cnt_pkg;

  // Operating mode; the reserved code behaves exactly like wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  // One-shot sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cnt_updn_mod.sv
// Parametrised up/down modulo counter with runtime terminal value,
// parallel load, and wrap / saturate / one-shot behaviour. cout is
// combinational so a chained stage (cout -> en) advances in the same
// cycle that this stage reaches its terminal count.
module cnt_updn_mod
  import cnt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] max,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             wrap_reg, wrap_next;
  state_t           state_reg, state_next;

  mode_t            mode_sel;
  logic             is_oneshot;
  logic             term;
  logic [WIDTH-1:0] step;

  assign mode_sel   = mode_t'(mode);
  assign is_oneshot = (mode_sel == MODE_ONESHOT);

  // Terminal detect, plain +/-1 step and the status outputs. Counting
  // up uses >= so a max lowered below the current count still terminates.
  always_comb begin
    term = up ? (cnt_reg >= max) : (cnt_reg == '0);
    step = up ? (cnt_reg + WIDTH'(1)) : (cnt_reg - WIDTH'(1));
    busy = is_oneshot ? (state_reg == ST_RUN) : 1'b1;
    cout = en & term & busy;
    done = is_oneshot & (state_reg == ST_DONE);
  end

  // Next count, wrap pulse and sequencer state; load beats start beats en.
  always_comb begin
    cnt_next   = cnt_reg;
    wrap_next  = 1'b0;
    state_next = state_reg;
    if (load) begin
      cnt_next = din;
    end else if (is_oneshot && start) begin
      cnt_next   = up ? '0 : max;
      state_next = ST_RUN;
    end else if (en) begin
      case (mode_sel)
        MODE_SAT: begin
          // Above max while counting up: clamp; at terminal: hold.
          if (up && (cnt_reg > max)) begin
            cnt_next = max;
          end else if (!term) begin
            cnt_next = step;
          end
        end
        MODE_ONESHOT: begin
          // Only RUN counts; the terminal step parks the count in DONE.
          if (state_reg == ST_RUN) begin
            if (term) begin
              state_next = ST_DONE;
            end else begin
              cnt_next = step;
            end
          end
        end
        default: begin
          if (term) begin
            cnt_next  = up ? '0 : max;
            wrap_next = 1'b1;
          end else begin
            cnt_next = step;
          end
        end
      endcase
    end
    // Leaving one-shot mode always returns the sequencer to IDLE.
    if (!is_oneshot) begin
      state_next = ST_IDLE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      wrap_reg  <= 1'b0;
      state_reg <= ST_IDLE;
    end else begin
      cnt_reg   <= cnt_next;
      wrap_reg  <= wrap_next;
      state_reg <= state_next;
    end
  end

  assign dout = cnt_reg;
  assign wrap = wrap_reg;

endmodule
